// File: rtl/xi_seq_ctrl.sv
// xi_seq_ctrl: runs the HqA -> YGA -> trace_cal -> qdiv chain once per xI term and publishes each quotient,
// with a per-stage watchdog that turns a stalled stage into a timeout error.
module xi_seq_ctrl #(
   parameter int NUM_X   = 4,
   parameter int IDX_W   = 2,
   parameter int TMO_CYC = 64,
   parameter int DW      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [IDX_W-1:0] sel_idx,
   output logic             hqa_start,
   input  logic             hqa_ready,
   output logic             trc_en,
   input  logic             trc_finish,
   output logic             div_start,
   input  logic             div_complete,
   input  logic [DW-1:0]    div_quot,
   input  logic             div_ovf,
   output logic             xi_valid,
   output logic [IDX_W-1:0] xi_idx,
   output logic [DW-1:0]    xi_data,
   output logic             xi_ovf
);
   localparam int CW = $clog2(TMO_CYC);
   typedef enum logic [2:0] {IDLE, W_HQA, W_TRC, W_DIV, PUB, FIN} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic tmo, wt, last;
   assign wt   = state inside {W_HQA, W_TRC, W_DIV};
   assign tmo  = cnt == CW'(TMO_CYC - 1);
   assign last = sel_idx == IDX_W'(NUM_X - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   // a completion flag beats the watchdog in the same cycle; abort beats both
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? W_HQA : IDLE;
         W_HQA:   nxt = hqa_ready ? W_TRC : tmo ? FIN : W_HQA;
         W_TRC:   nxt = trc_finish ? W_DIV : tmo ? FIN : W_TRC;
         W_DIV:   nxt = div_complete ? PUB : tmo ? FIN : W_DIV;
         PUB:     nxt = last ? FIN : W_HQA;
         default: nxt = IDLE;
      endcase
      if (abort && state != IDLE) nxt = IDLE;
   end
   always_comb begin
      busy      = state != IDLE;
      done      = state == FIN;
      hqa_start = state == W_HQA && cnt == '0;
      trc_en    = state == W_TRC && cnt == '0;
      div_start = state == W_DIV && cnt == '0;
      xi_valid  = state == PUB;
      xi_idx    = sel_idx;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt         <= '0;
         sel_idx     <= '0;
         err_timeout <= 1'b0;
         xi_data     <= '0;
         xi_ovf      <= 1'b0;
      end else begin
         cnt <= (nxt != state || !wt) ? '0 : cnt + 1'b1;
         if (state == IDLE && start) begin
            sel_idx     <= '0;
            err_timeout <= 1'b0;
         end else if (wt && nxt == FIN) err_timeout <= 1'b1;
         if (state == PUB && nxt == W_HQA) sel_idx <= sel_idx + 1'b1;
         if (state == W_DIV && nxt == PUB) begin
            xi_data <= div_quot;
            xi_ovf  <= div_ovf;
         end
      end
endmodule

// File: tb/tb_xi_seq_ctrl.sv
// tb_xi_seq_ctrl: stage responders with programmable reply delays feed the sequencer;
// expected publications are queued at start and popped as xi_valid pulses appear.
module tb_xi_seq_ctrl;
   localparam int NUM_X = 4, IDX_W = 2, TMO_CYC = 64, DW = 16;
   logic clk = 0, rst = 0, start = 0, abort = 0;
   logic hqa_ready = 0, trc_finish = 0, div_complete = 0, div_ovf = 0;
   logic [DW-1:0] div_quot = '0;
   logic busy, done, err_timeout, hqa_start, trc_en, div_start, xi_valid, xi_ovf;
   logic [IDX_W-1:0] sel_idx, xi_idx;
   logic [DW-1:0] xi_data;

   xi_seq_ctrl #(.NUM_X(NUM_X), .IDX_W(IDX_W), .TMO_CYC(TMO_CYC), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .err_timeout(err_timeout), .sel_idx(sel_idx), .hqa_start(hqa_start), .hqa_ready(hqa_ready),
      .trc_en(trc_en), .trc_finish(trc_finish), .div_start(div_start), .div_complete(div_complete),
      .div_quot(div_quot), .div_ovf(div_ovf), .xi_valid(xi_valid), .xi_idx(xi_idx),
      .xi_data(xi_data), .xi_ovf(xi_ovf));

   always #5 clk = ~clk;

   typedef struct packed {logic [IDX_W-1:0] idx; logic [DW-1:0] data; logic ovf;} exp_t;
   exp_t sb[$];
   int cyc = 0, n_chk = 0, n_fail = 0, n_valid = 0, n_done = 0, t_last_valid = 0;
   int d_hqa = 3, d_trc = 5, d_div = 7, stall_k = -1, trc_n = 0, div_n = 0, q_step = 0;
   logic [DW-1:0] q_base = '0;
   logic ovf_cfg = 0;

   always @(posedge clk) cyc++;

   initial forever begin
      @(negedge clk);
      if (hqa_start) begin
         repeat (d_hqa) @(negedge clk);
         hqa_ready = 1;
         @(negedge clk);
         hqa_ready = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (trc_en) begin
         trc_n++;
         if (trc_n - 1 != stall_k) begin
            repeat (d_trc) @(negedge clk);
            trc_finish = 1;
            @(negedge clk);
            trc_finish = 0;
         end
      end
   end

   // quotient is only valid during the completion cycle; garbage otherwise
   initial forever begin
      @(negedge clk);
      if (div_start) begin
         repeat (d_div) @(negedge clk);
         div_quot = q_base + DW'(q_step * div_n);
         div_ovf = ovf_cfg;
         div_complete = 1;
         div_n++;
         @(negedge clk);
         div_complete = 0;
         div_quot = 16'hdead;
         div_ovf = 0;
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (hqa_start || trc_en || div_start) begin
         n_chk++;
         if (int'(hqa_start) + int'(trc_en) + int'(div_start) !== 1) begin
            n_fail++;
            $display("FAIL strobe_onehot: got %b%b%b required at most one", hqa_start, trc_en, div_start);
         end
      end
      if (done) n_done++;
      if (xi_valid) begin
         n_valid++;
         t_last_valid = cyc;
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL xi_unexpected: got idx=%0d data=%h with no publication expected", xi_idx, xi_data);
         end else begin
            e = sb.pop_front();
            if ({xi_idx, xi_data, xi_ovf} !== {e.idx, e.data, e.ovf}) begin
               n_fail++;
               $display("FAIL xi_pub: got idx=%0d data=%h ovf=%b required idx=%0d data=%h ovf=%b",
                        xi_idx, xi_data, xi_ovf, e.idx, e.data, e.ovf);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, required finish within 300us");
      $fatal(1, "global timeout");
   end

   task automatic setup(input int h, input int t, input int d, input logic [DW-1:0] base,
                        input int step, input logic ovf, input int n_push);
      d_hqa = h; d_trc = t; d_div = d; q_base = base; q_step = step; ovf_cfg = ovf;
      for (int k = 0; k < n_push; k++) sb.push_back({IDX_W'(k), base + DW'(step * k), ovf});
   endtask

   task automatic do_start(output int t0);
      @(negedge clk);
      start = 1; trc_n = 0; div_n = 0; t0 = cyc;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input int bound, output int t);
      t = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({busy, done, err_timeout, sel_idx, hqa_start, trc_en, div_start, xi_valid, xi_idx, xi_data, xi_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b sel=%0d xi_data=%h required all 0", busy, done, err_timeout, sel_idx, xi_data);
      end
      rst = 1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b required 0", busy); end
   endtask

   task automatic test_normal;
      int t0, t;
      setup(3, 5, 7, 16'h0100, 0, 1'b0, NUM_X);
      do_start(t0);
      wait_done(300, t);
      n_chk++;
      if (t - t0 !== 77) begin n_fail++; $display("FAIL normal_latency: got %0d required 77", t - t0); end
      n_chk++;
      if (t - t_last_valid !== 1) begin n_fail++; $display("FAIL normal_done_after_pub: got %0d required 1", t - t_last_valid); end
      n_chk++;
      if (sb.size() !== 0) begin n_fail++; $display("FAIL normal_count: got %0d missing required 0", sb.size()); end
      n_chk++;
      if ({err_timeout, xi_data} !== {1'b0, 16'h0100}) begin
         n_fail++;
         $display("FAIL normal_final: got err=%b data=%h required err=0 data=0100", err_timeout, xi_data);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL normal_idle: got busy=%b required 0", busy); end
   endtask

   task automatic test_reset_midrun;
      int t0, nd, nv;
      bit seen;
      setup(3, 5, 7, 16'h0100, 0, 1'b0, 0);
      nd = n_done; nv = n_valid; seen = 0;
      do_start(t0);
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = trc_en;
      end
      n_chk++;
      if (!seen) begin n_fail++; $display("FAIL midrun_trc_en: got none required trc_en within 30 cycles"); end
      @(negedge clk);
      #2 rst = 0;
      #1;
      n_chk++;
      if ({busy, done, err_timeout, sel_idx, hqa_start, trc_en, div_start, xi_valid, xi_idx, xi_data, xi_ovf} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: got busy=%b sel=%0d xi_data=%h required all 0", busy, sel_idx, xi_data);
      end
      @(negedge clk);
      rst = 1;
      repeat (20) @(negedge clk);
      n_chk++;
      if ({busy, n_done - nd, n_valid - nv} !== {1'b0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL midrun_no_pulses: got busy=%b done=%0d valid=%0d required 0 0 0", busy, n_done - nd, n_valid - nv);
      end
   endtask

   task automatic test_timeout;
      int t0, t, t_trc, ntrc, nv;
      setup(3, 5, 7, 16'h1000, 1, 1'b0, 2);
      stall_k = 2; nv = n_valid; t = -1; t_trc = -1; ntrc = 0;
      do_start(t0);
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (trc_en) begin
            ntrc++;
            if (ntrc == 3) t_trc = cyc;
         end
         if (done) begin
            t = cyc;
            break;
         end
      end
      n_chk++;
      if (t - t_trc !== TMO_CYC) begin n_fail++; $display("FAIL tmo_done_delay: got %0d required %0d", t - t_trc, TMO_CYC); end
      n_chk++;
      if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", err_timeout); end
      n_chk++;
      if (n_valid - nv !== 2) begin n_fail++; $display("FAIL tmo_valid_count: got %0d required 2", n_valid - nv); end
      repeat (5) @(negedge clk);
      n_chk++;
      if ({busy, err_timeout} !== 2'b01) begin n_fail++; $display("FAIL tmo_sticky: got busy=%b err=%b required 0 1", busy, err_timeout); end
      stall_k = -1;
      setup(3, 5, 7, 16'h2000, 1, 1'b0, NUM_X);
      do_start(t0);
      n_chk++;
      if ({busy, err_timeout} !== 2'b10) begin n_fail++; $display("FAIL tmo_clear: got busy=%b err=%b required 1 0", busy, err_timeout); end
      wait_done(300, t);
      n_chk++;
      if ({t - t0, err_timeout} !== {32'd77, 1'b0}) begin
         n_fail++;
         $display("FAIL tmo_rerun: got latency=%0d err=%b required 77 0", t - t0, err_timeout);
      end
   endtask

   task automatic test_boundary;
      int t0, t;
      setup(0, TMO_CYC - 1, 0, 16'h8100, 1, 1'b1, NUM_X);
      do_start(t0);
      wait_done(600, t);
      n_chk++;
      if (t - t0 !== NUM_X * (TMO_CYC - 1 + 4) + 1) begin
         n_fail++;
         $display("FAIL bnd_latency: got %0d required %0d", t - t0, NUM_X * (TMO_CYC - 1 + 4) + 1);
      end
      n_chk++;
      if ({err_timeout, xi_ovf, xi_data} !== {1'b0, 1'b1, 16'h8103}) begin
         n_fail++;
         $display("FAIL bnd_final: got err=%b ovf=%b data=%h required 0 1 8103", err_timeout, xi_ovf, xi_data);
      end
      n_chk++;
      if (sb.size() !== 0) begin n_fail++; $display("FAIL bnd_count: got %0d missing required 0", sb.size()); end
   endtask

   task automatic test_abort_ignore;
      int t0, t, nd, nv;
      bit seen;
      setup(2, 2, 4, 16'h5500, 1, 1'b0, 0);
      nd = n_done; nv = n_valid; seen = 0;
      @(negedge clk);
      start = 1; abort = 1; trc_n = 0; div_n = 0;
      @(negedge clk);
      start = 0; abort = 0;
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_start: got busy=%b required 1", busy); end
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = div_start;
      end
      n_chk++;
      if (!seen) begin n_fail++; $display("FAIL abort_div_start: got none required div_start within 40 cycles"); end
      repeat (4) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b required 0", busy); end
      repeat (10) @(negedge clk);
      n_chk++;
      if ({n_done - nd, n_valid - nv} !== {32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL abort_no_pulses: got done=%0d valid=%0d required 0 0", n_done - nd, n_valid - nv);
      end
      n_chk++;
      if ({xi_data, xi_ovf, err_timeout} !== {16'h8103, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_hold: got data=%h ovf=%b err=%b required 8103 1 0", xi_data, xi_ovf, err_timeout);
      end
      setup(3, 5, 7, 16'h6600, 1, 1'b0, NUM_X);
      do_start(t0);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = div_start;
      end
      @(negedge clk);
      start = 1; hqa_ready = 1;
      @(negedge clk);
      start = 0; hqa_ready = 0;
      wait_done(300, t);
      n_chk++;
      if (t - t0 !== 77) begin n_fail++; $display("FAIL ignore_latency: got %0d required 77", t - t0); end
      n_chk++;
      if ({sb.size(), xi_data} !== {32'd0, 16'h6603}) begin
         n_fail++;
         $display("FAIL ignore_final: got missing=%0d data=%h required 0 6603", sb.size(), xi_data);
      end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_reset_midrun;
      test_timeout;
      test_boundary;
      test_abort_ignore;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
